// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge: SRAM-like fetch interface (req/addr_ok/data_ok) to a
// single-ID, in-order AXI4 read channel pair (AR/R).
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID      = 4'd0,
  parameter int         MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [2:0]  outst_cnt,
  output logic        rd_err
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

  ar_state_e state, state_nxt;
  logic [2:0] cnt;
  logic       beat;
  logic       slot_free;

  // Write-side fields and rid carry no meaning for an in-order read-only path.
  logic unused_in;
  assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

  assign rready            = (cnt != 3'd0);
  assign beat              = rvalid & rready;
  assign inst_sram_data_ok = beat & rlast;
  assign inst_sram_rdata   = rdata;
  assign outst_cnt         = cnt;

  // A slot being freed by this cycle's data_ok can be reused in the same cycle.
  assign slot_free = (cnt < MAX_CNT) | inst_sram_data_ok;

  always_comb begin
    state_nxt         = state;
    inst_sram_addr_ok = 1'b0;
    arvalid           = 1'b0;
    case (state)
      AR_IDLE: begin
        inst_sram_addr_ok = resetn & inst_sram_req & slot_free;
        if (inst_sram_addr_ok) state_nxt = AR_SEND;
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) state_nxt = AR_IDLE;
      end
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= AR_IDLE;
      araddr <= 32'd0;
      arsize <= 3'd0;
    end else begin
      state <= state_nxt;
      if (inst_sram_addr_ok) begin
        araddr <= inst_sram_addr;
        arsize <= {1'b0, inst_sram_size};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= 3'd0;
      rd_err <= 1'b0;
    end else begin
      case ({inst_sram_addr_ok, inst_sram_data_ok})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
      if (beat && rresp != 2'b00) rd_err <= 1'b1;
    end
  end

endmodule
